// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/busy/done handshake and operand/result bus for serial_subtractor
// Signals: start, a, b, bin driven by the master; busy, done, diff, bout, ovf driven by the slave.
// Modports: master (requester), slave (subtractor).
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
    modport master (output start, a, b, bin, input busy, done, diff, bout, ovf);
    modport slave  (input start, a, b, bin, output busy, done, diff, bout, ovf);
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: digit-serial a - b - bin over WIDTH bits, DIGIT bits per clock
// Ports: clk (rising edge), rst_n (async active-low), bus (serial_subtractor_if.slave):
//   start/a/b/bin in, busy/done/diff/bout/ovf out. done pulses one cycle; diff/bout/ovf
//   hold until the next completion.
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input logic                  clk,
    input logic                  rst_n,
    serial_subtractor_if.slave   bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    if (WIDTH < 1 || DIGIT < 1 || WIDTH % DIGIT != 0) begin : g_bad
        $error("serial_subtractor: WIDTH must be a positive multiple of DIGIT");
    end
    typedef enum logic {IDLE, RUN} state_t;
    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, r_q, diff_q;
    logic             brw_q, busy_q, done_q, bout_q, ovf_q;
    logic [CW-1:0]    cnt_q;
    logic [DIGIT:0]   s;
    logic [WIDTH+DIGIT-1:0] rs;
    logic [WIDTH-1:0] r_d;
    logic             msb_bin_d;
    always_comb begin
        s  = {1'b0, a_q[DIGIT-1:0]} - {1'b0, b_q[DIGIT-1:0]} - {{DIGIT{1'b0}}, brw_q};
        // New digit enters at the MSB end; the concat keeps WIDTH==DIGIT legal.
        rs = {s[DIGIT-1:0], r_q};
        r_d = rs[WIDTH+DIGIT-1:DIGIT];
        // Borrow into the top bit of the digit, recovered from d = a ^ b ^ borrow_in.
        msb_bin_d = s[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            diff_q  <= '0;
            brw_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            if (state_q == IDLE) begin
                if (bus.start) begin
                    a_q     <= bus.a;
                    b_q     <= bus.b;
                    brw_q   <= bus.bin;
                    cnt_q   <= '0;
                    busy_q  <= 1'b1;
                    state_q <= RUN;
                end
            end else begin
                a_q   <= a_q >> DIGIT;
                b_q   <= b_q >> DIGIT;
                r_q   <= r_d;
                brw_q <= s[DIGIT];
                cnt_q <= cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    diff_q  <= r_d;
                    bout_q  <= s[DIGIT];
                    ovf_q   <= msb_bin_d ^ s[DIGIT];
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
            end
        end
    end
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
    assign bus.ovf  = ovf_q;
endmodule
